arm7tdmi_dcc_fifo: RTL and testbench
====================================

Name: arm7tdmi_dcc_fifo

Overview:
Parametrised Debug Communications Channel (DCC) between the processor core (CP14 MCR/MRC side) and the debugger host side. The debugger side is fed from EmbeddedICE logic that has already been synchronised into the core clock domain. It generalises the classic single-entry comms registers into two independent FIFOs: host-to-core (H2C) and core-to-host (C2H). Both FIFOs have configurable width and depth, fill levels, sticky overflow/underflow flags, flush, and COMMRX/COMMTX interrupt outputs.

Parameters:
DATA_W, 32, data word width of both FIFOs
DEPTH, 4, entries per FIFO; must be a power of 2, 2..128
VERSION, 4'h1, DCC version reported in core_status[31:28]
LVL_W, $clog2(DEPTH+1), fill-level width (derived, not overridden)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
core_wr_en  in  1  core pushes core_wr_data into C2H (MCR to comms data)
core_wr_data  in  DATA_W  core write data
core_rd_en  in  1  core pops H2C head (MRC from comms data)
core_rd_data  out  DATA_W  H2C head, first-word fall-through; 0 when empty
core_status  out  32  comms control word (layout under Behaviour)
host_tx_valid  in  1  host offers a word for H2C
host_tx_data  in  DATA_W  host word
host_tx_ready  out  1  H2C not full
host_rx_valid  out  1  C2H not empty
host_rx_data  out  DATA_W  C2H head, first-word fall-through; 0 when empty
host_rx_ready  in  1  host pops C2H when host_rx_valid is also high
flush  in  1  synchronous clear of both FIFOs and all sticky flags
clr_err  in  1  synchronous clear of the sticky flags only
commrx  out  1  interrupt: H2C non-empty
commtx  out  1  interrupt: C2H has space
h2c_level  out  LVL_W  H2C occupancy
c2h_level  out  LVL_W  C2H occupancy

Behaviour:
- Reset (asynchronous, takes effect at any cycle, including mid-transfer):
  - pointers, levels and sticky flags go to 0;
  - contents are don't-care, but head outputs read as 0.
  - Resulting outputs: host_tx_ready=1, host_rx_valid=0, commrx=0, commtx=1, core_status=={VERSION,28'h0} except bit1=0.
- Each FIFO is a circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits that wrap naturally, plus a level counter. full = (level==DEPTH); empty = (level==0).
- Push/pop take effect at the clk edge. Heads and levels update in the next cycle (latency 1); no combinational path runs from the enable inputs to the data outputs.
- Push rules:
  - H2C pushes when host_tx_valid && host_tx_ready.
  - C2H pushes when core_wr_en && !c2h_full.
  - core_wr_en while C2H is full: word dropped, sticky c2h_ovf set.
  - A host_tx_valid that is not accepted is held by the host (valid/ready; no overflow possible).
- Pop rules:
  - C2H pops when host_rx_valid && host_rx_ready.
  - H2C pops when core_rd_en && !h2c_empty.
  - core_rd_en while H2C is empty: no state change, sticky h2c_unf set, core_rd_data=0.
- Simultaneous push and pop on one FIFO:
  - Full FIFO: the pop frees the slot, so core_wr_en is accepted, level is unchanged and no overflow is flagged. host_tx_ready stays 0 while full (ready does not depend on the pop).
  - Empty FIFO: the push succeeds and the pop is treated as an empty-pop (h2c_unf set for the core side); level becomes 1.
- flush has priority over every push/pop in the same cycle. Next cycle: both FIFOs are empty and all sticky flags are 0. clr_err clears only the sticky flags; a flag event in the same cycle as clr_err wins (the flag is set).
- core_status bit layout:
  - [0] R = !h2c_empty
  - [1] W = c2h_full
  - [2] c2h_ovf
  - [3] h2c_unf
  - [15:8] h2c_level zero-extended
  - [23:16] c2h_level zero-extended
  - [27:24] 0
  - [31:28] VERSION
- commrx = !h2c_empty; commtx = !c2h_full. Both are driven from registered state only.

Decomposition:
- Shared package arm7tdmi_pkg gets:
  - DCC status bit-position constants (DCC_R_BIT=0, DCC_W_BIT=1, DCC_OVF_BIT=2, DCC_UNF_BIT=3);
  - level/version field LSBs;
  - default DCC_DEPTH.
- Sub-module arm7tdmi_dcc_sync_fifo (DATA_W, DEPTH): push, pop, flush, dout, level, full, empty. Instantiated twice. Overflow/underflow detection and the status word live in the top.

Test Plan:
- Reset with DEPTH=4: host_tx_ready=1, host_rx_valid=0, commrx=0, commtx=1, core_status=32'h1000_0000.
- Host pushes 0xA0..0xA3 on consecutive cycles: host_tx_ready=0 after the 4th push, h2c_level=4, core_status[15:8]=4, R=1. Core then reads 0xA0,0xA1,0xA2,0xA3 in order, after which core_rd_data=0 and commrx=0.
- Core writes 5 words while host_rx_ready=0: c2h_level=4, W=1, commtx=0, c2h_ovf=1. Host drains 4 words (5th absent); clr_err clears c2h_ovf.
- C2H full, core_wr_en together with a host pop: level stays 4, no c2h_ovf, new word emerges last. core_rd_en on empty H2C together with host push 0x55: h2c_unf=1, h2c_level=1, core_rd_data=0x55 next cycle.
- Wrap: stream 10 words host→core, reading each cycle after the first: data order preserved, pointers wrap twice, no flags set.
- flush asserted the same cycle as a push and a pop with both FIFOs at level 2: both levels 0 next cycle, flags 0. Assert rst while levels are non-zero: outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/arm7tdmi_pkg.sv
// Shared constants and types for the ARM7TDMI debug comms channel.
package arm7tdmi_pkg;

  localparam int DCC_R_BIT   = 0;
  localparam int DCC_W_BIT   = 1;
  localparam int DCC_OVF_BIT = 2;
  localparam int DCC_UNF_BIT = 3;

  localparam int DCC_H2C_LVL_LSB = 8;
  localparam int DCC_C2H_LVL_LSB = 16;
  localparam int DCC_VER_LSB     = 28;
  localparam int DCC_LVL_FIELD_W = 8;
  localparam int DCC_VER_W       = 4;

  localparam int DCC_DEPTH = 4;

  typedef struct packed {
    logic h2c_unf;
    logic c2h_ovf;
  } dcc_err_t;

endpackage

// File: rtl/arm7tdmi_dcc_sync_fifo.sv
// Circular-buffer FIFO with level counter and first-word fall-through head.
// Latency: push/pop visible on dout/level one cycle after the edge.
// Backpressure: push ignored when full unless a pop frees the slot in the same cycle.
module arm7tdmi_dcc_sync_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int LVL_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] dout,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A pop on a full FIFO frees the slot this push lands in.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/arm7tdmi_dcc_fifo.sv
// Debug comms channel: host-to-core and core-to-host FIFOs with sticky error flags.
// Latency: 1 cycle from push/pop to head, level and status; outputs are register-driven.
// Backpressure: host side valid/ready; core writes to a full C2H are dropped and flagged.
module arm7tdmi_dcc_fifo
  import arm7tdmi_pkg::*;
#(
  parameter  int         DATA_W  = 32,
  parameter  int         DEPTH   = DCC_DEPTH,
  parameter  logic [3:0] VERSION = 4'h1,
  localparam int         LVL_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_wr_en,
  input  logic [DATA_W-1:0] core_wr_data,
  input  logic              core_rd_en,
  output logic [DATA_W-1:0] core_rd_data,
  output logic [31:0]       core_status,
  input  logic              host_tx_valid,
  input  logic [DATA_W-1:0] host_tx_data,
  output logic              host_tx_ready,
  output logic              host_rx_valid,
  output logic [DATA_W-1:0] host_rx_data,
  input  logic              host_rx_ready,
  input  logic              flush,
  input  logic              clr_err,
  output logic              commrx,
  output logic              commtx,
  output logic [LVL_W-1:0]  h2c_level,
  output logic [LVL_W-1:0]  c2h_level
);

  logic     h2c_full, h2c_empty;
  logic     c2h_full, c2h_empty;
  logic     h2c_push, c2h_pop;
  logic     ovf_ev, unf_ev;
  dcc_err_t err_q;

  assign h2c_push = host_tx_valid && !h2c_full;
  assign c2h_pop  = host_rx_ready && !c2h_empty;
  assign ovf_ev   = core_wr_en && c2h_full && !c2h_pop;
  assign unf_ev   = core_rd_en && h2c_empty;

  arm7tdmi_dcc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_h2c (
    .clk   (clk),
    .rst   (rst),
    .push  (h2c_push),
    .din   (host_tx_data),
    .pop   (core_rd_en),
    .flush (flush),
    .dout  (core_rd_data),
    .level (h2c_level),
    .full  (h2c_full),
    .empty (h2c_empty)
  );

  arm7tdmi_dcc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_c2h (
    .clk   (clk),
    .rst   (rst),
    .push  (core_wr_en),
    .din   (core_wr_data),
    .pop   (c2h_pop),
    .flush (flush),
    .dout  (host_rx_data),
    .level (c2h_level),
    .full  (c2h_full),
    .empty (c2h_empty)
  );

  // A new error event outranks clr_err so a same-cycle event is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (flush) begin
      err_q <= '0;
    end else begin
      err_q.c2h_ovf <= ovf_ev || (err_q.c2h_ovf && !clr_err);
      err_q.h2c_unf <= unf_ev || (err_q.h2c_unf && !clr_err);
    end
  end

  assign host_tx_ready = !h2c_full;
  assign host_rx_valid = !c2h_empty;
  assign commrx        = !h2c_empty;
  assign commtx        = !c2h_full;

  always_comb begin
    core_status                                            = '0;
    core_status[DCC_R_BIT]                                 = !h2c_empty;
    core_status[DCC_W_BIT]                                 = c2h_full;
    core_status[DCC_OVF_BIT]                               = err_q.c2h_ovf;
    core_status[DCC_UNF_BIT]                               = err_q.h2c_unf;
    core_status[DCC_H2C_LVL_LSB +: DCC_LVL_FIELD_W]        = DCC_LVL_FIELD_W'(h2c_level);
    core_status[DCC_C2H_LVL_LSB +: DCC_LVL_FIELD_W]        = DCC_LVL_FIELD_W'(c2h_level);
    core_status[DCC_VER_LSB +: DCC_VER_W]                  = VERSION;
  end

endmodule

// File: tb/tb_arm7tdmi_dcc_fifo.sv
// Self-checking bench for arm7tdmi_dcc_fifo: queue model plus directed literal checks.
module tb_arm7tdmi_dcc_fifo;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int LW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          core_wr_en, core_rd_en, host_tx_valid, host_rx_ready, flush, clr_err;
  logic [DW-1:0] core_wr_data, host_tx_data;
  logic [DW-1:0] core_rd_data, host_rx_data;
  logic [31:0]   core_status;
  logic          host_tx_ready, host_rx_valid, commrx, commtx;
  logic [LW-1:0] h2c_level, c2h_level;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] h2c_q[$];
  logic [DW-1:0] c2h_q[$];
  logic          m_ovf, m_unf;

  always #5 clk = ~clk;

  arm7tdmi_dcc_fifo #(.DATA_W(DW), .DEPTH(DP), .VERSION(4'h1)) dut (
    .clk(clk), .rst(rst),
    .core_wr_en(core_wr_en), .core_wr_data(core_wr_data),
    .core_rd_en(core_rd_en), .core_rd_data(core_rd_data),
    .core_status(core_status),
    .host_tx_valid(host_tx_valid), .host_tx_data(host_tx_data), .host_tx_ready(host_tx_ready),
    .host_rx_valid(host_rx_valid), .host_rx_data(host_rx_data), .host_rx_ready(host_rx_ready),
    .flush(flush), .clr_err(clr_err),
    .commrx(commrx), .commtx(commtx),
    .h2c_level(h2c_level), .c2h_level(c2h_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    h2c_q.delete();
    c2h_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  always @(posedge rst) model_clear();

  // Model: what each FIFO holds after this edge, from the rules on the inputs.
  always @(posedge clk) begin
    if (rst) begin
      model_clear();
    end else begin
      bit h_push, h_pop, c_push, c_pop, ovf_e, unf_e;
      h_push = host_tx_valid && (h2c_q.size() < DP);
      h_pop  = core_rd_en && (h2c_q.size() > 0);
      c_pop  = host_rx_ready && (c2h_q.size() > 0);
      c_push = core_wr_en && ((c2h_q.size() < DP) || c_pop);
      ovf_e  = core_wr_en && !c_push;
      unf_e  = core_rd_en && (h2c_q.size() == 0);
      if (flush) begin
        model_clear();
      end else begin
        if (h_pop)  void'(h2c_q.pop_front());
        if (c_pop)  void'(c2h_q.pop_front());
        if (h_push) h2c_q.push_back(host_tx_data);
        if (c_push) c2h_q.push_back(core_wr_data);
        m_ovf = ovf_e || (m_ovf && !clr_err);
        m_unf = unf_e || (m_unf && !clr_err);
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e_stat;
    int hn, cn;
    hn = h2c_q.size();
    cn = c2h_q.size();
    e_stat = {4'h1, 4'h0, 8'(cn), 8'(hn), 4'h0, m_unf, m_ovf, (cn == DP), (hn != 0)};
    chk("m_core_rd_data", core_rd_data, (hn == 0) ? 32'h0 : h2c_q[0]);
    chk("m_host_rx_data", host_rx_data, (cn == 0) ? 32'h0 : c2h_q[0]);
    chk("m_status", core_status, e_stat);
    chk("m_handshake", {28'h0, host_tx_ready, host_rx_valid, commrx, commtx},
        {28'h0, hn != DP, cn != 0, hn != 0, cn != DP});
    chk("m_levels", {26'h0, h2c_level, c2h_level}, {26'h0, LW'(hn), LW'(cn)});
  end

  task automatic idle();
    core_wr_en = 0; core_rd_en = 0; host_tx_valid = 0; host_rx_ready = 0;
    flush = 0; clr_err = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    core_wr_data = '0;
    host_tx_data = '0;
    tick();
    chk("rst_status", core_status, 32'h1000_0000);
    chk("rst_hs", {host_tx_ready, host_rx_valid, commrx, commtx}, 4'b1001);
    rst = 1'b0;
    tick();

    // host fills H2C, core drains it in order
    for (int i = 0; i < 4; i++) begin
      host_tx_valid = 1; host_tx_data = 32'hA0 + i;
      tick();
    end
    idle();
    chk("h2c_full_ready", {31'h0, host_tx_ready}, 32'h0);
    chk("h2c_lvl4", {29'h0, h2c_level}, 32'd4);
    chk("h2c_stat_lvl", {24'h0, core_status[15:8]}, 32'd4);
    chk("h2c_R", {31'h0, core_status[0]}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("core_rd_order", core_rd_data, 32'hA0 + i);
      core_rd_en = 1;
      tick();
    end
    idle();
    chk("core_rd_empty", core_rd_data, 32'h0);
    chk("commrx_off", {31'h0, commrx}, 32'h0);

    // C2H overflow then drain and clear
    for (int i = 0; i < 5; i++) begin
      core_wr_en = 1; core_wr_data = 32'hB0 + i;
      tick();
    end
    idle();
    chk("c2h_lvl4", {29'h0, c2h_level}, 32'd4);
    chk("c2h_W_ovf", {28'h0, core_status[3:0]}, 32'h6);
    chk("commtx_off", {31'h0, commtx}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("host_rx_order", host_rx_data, 32'hB0 + i);
      host_rx_ready = 1;
      tick();
    end
    idle();
    chk("host_rx_empty", {31'h0, host_rx_valid}, 32'h0);
    clr_err = 1;
    tick();
    idle();
    chk("clr_err_ovf", {31'h0, core_status[2]}, 32'h0);

    // full C2H write with simultaneous host pop
    for (int i = 0; i < 4; i++) begin
      core_wr_en = 1; core_wr_data = 32'hC0 + i;
      tick();
    end
    core_wr_data = 32'hC4; host_rx_ready = 1;
    tick();
    idle();
    chk("fullpush_lvl", {29'h0, c2h_level}, 32'd4);
    chk("fullpush_noovf", {31'h0, core_status[2]}, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      chk("fullpush_order", host_rx_data, 32'hC0 + i);
      host_rx_ready = 1;
      tick();
    end
    idle();

    // empty H2C read with simultaneous host push
    core_rd_en = 1; host_tx_valid = 1; host_tx_data = 32'h55;
    tick();
    idle();
    chk("emptypop_unf", {31'h0, core_status[3]}, 32'h1);
    chk("emptypop_lvl", {29'h0, h2c_level}, 32'd1);
    chk("emptypop_data", core_rd_data, 32'h55);
    core_rd_en = 1; clr_err = 1;
    tick();
    idle();
    chk("unf_cleared", core_status, 32'h1000_0000);

    // pointer wrap: 10 words streamed through
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin
        chk("wrap_data", core_rd_data, 32'hD0 + k - 1);
        core_rd_en = 1;
      end
      host_tx_valid = (k < 10);
      host_tx_data  = 32'hD0 + k;
      tick();
    end
    idle();
    chk("wrap_final", core_status, 32'h1000_0000);

    // flush beats push/pop at level 2, also clears a pending flag
    core_rd_en = 1;
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      host_tx_valid = 1; host_tx_data = 32'hE0 + i;
      core_wr_en = 1; core_wr_data = 32'hF0 + i;
      tick();
    end
    idle();
    chk("preflush", core_status, 32'h1002_0209);
    flush = 1; host_tx_valid = 1; core_wr_en = 1; core_rd_en = 1; host_rx_ready = 1;
    tick();
    idle();
    chk("postflush", core_status, 32'h1000_0000);
    chk("postflush_lvls", {26'h0, h2c_level, c2h_level}, 32'h0);

    // asynchronous reset mid-cycle
    for (int i = 0; i < 2; i++) begin
      host_tx_valid = 1; host_tx_data = 32'h70 + i;
      core_wr_en = 1; core_wr_data = 32'h80 + i;
      tick();
    end
    idle();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_status", core_status, 32'h1000_0000);
    chk("arst_hs", {host_tx_ready, host_rx_valid, commrx, commtx}, 4'b1001);
    chk("arst_heads", core_rd_data | host_rx_data, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
